// File: rtl/done_track_n_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | done_track_n_pkg : shared types and helpers for done_track_n       |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
package done_track_n_pkg;

   // One rail of a dual-rail bit.
   typedef logic Dual;

   localparam int DEF_BITS = 4;

   typedef enum logic [1:0] {
      WAIT_SPACER = 2'd0,
      ARMED       = 2'd1,
      DONE        = 2'd2
   } state_e;

   function automatic int cnt_width(input int timeout);
      return (timeout < 1) ? 1 : $clog2(timeout + 1);
   endfunction

endpackage
`default_nettype wire

// File: rtl/done_track_n_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | done_track_n_if : rail inputs, handshake and status of done_track_n|
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
interface done_track_n_if
   import done_track_n_pkg::*;
#(
   parameter int N    = 2,
   parameter int BITS = DEF_BITS
);
   Dual  [N-1:0][BITS-1:0] val0;
   Dual  [N-1:0][BITS-1:0] val1;
   logic [N-1:0]           ack;
   logic [N-1:0]           err_clr;
   logic [N-1:0]           done;
   logic [N-1:0]           done_pulse;
   logic                   all_done;
   logic [N-1:0]           err;

   modport master (
      output val0, val1, ack, err_clr,
      input  done, done_pulse, all_done, err
   );

   modport slave (
      input  val0, val1, ack, err_clr,
      output done, done_pulse, all_done, err
   );
endinterface
`default_nettype wire

// File: rtl/done_track_n_chan.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | done_chan : one dual-rail channel -- sync, four-phase FSM, timeout |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module done_chan
   import done_track_n_pkg::*;
#(
   parameter int BITS        = DEF_BITS,
   parameter int SYNC_STAGES = 2,
   parameter int TIMEOUT     = 16
) (
   input  wire logic            clk,
   input  wire logic            rst_n,
   input  wire Dual [BITS-1:0]  val0,
   input  wire Dual [BITS-1:0]  val1,
   input  wire logic            ack,
   input  wire logic            err_clr,
   output logic                 done,
   output logic                 done_pulse,
   output logic                 err
);
   logic [BITS-1:0]        w_diff;
   logic                   w_raw_complete;
   logic                   w_raw_spacer;
   logic [SYNC_STAGES-1:0] r_sync_c;
   logic [SYNC_STAGES-1:0] r_sync_s;
   logic                   w_s_complete;
   logic                   w_s_spacer;
   state_e                 r_state;
   state_e                 w_state_nxt;
   logic                   r_done;
   logic                   r_pulse;

   assign w_diff         = val0 ^ val1;
   assign w_raw_complete = &w_diff;
   assign w_raw_spacer   = ~|w_diff;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sync_c <= '0;
         r_sync_s <= '0;
      end else begin
         r_sync_c <= {r_sync_c[SYNC_STAGES-2:0], w_raw_complete};
         r_sync_s <= {r_sync_s[SYNC_STAGES-2:0], w_raw_spacer};
      end
   end

   // Complete wins if a transient makes both synchronised views read 1.
   assign w_s_complete = r_sync_c[SYNC_STAGES-1];
   assign w_s_spacer   = r_sync_s[SYNC_STAGES-1] & ~w_s_complete;

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         WAIT_SPACER: if (w_s_spacer)   w_state_nxt = ARMED;
         ARMED:       if (w_s_complete) w_state_nxt = DONE;
         DONE:        if (ack)          w_state_nxt = WAIT_SPACER;
         default:                       w_state_nxt = WAIT_SPACER;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= WAIT_SPACER;
         r_done  <= 1'b0;
         r_pulse <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_done  <= (w_state_nxt == DONE);
         r_pulse <= (r_state == ARMED) && (w_state_nxt == DONE);
      end
   end

   assign done       = r_done;
   assign done_pulse = r_pulse;

   generate
      if (TIMEOUT > 0) begin : g_timeout
         localparam int CW = cnt_width(TIMEOUT);
         logic [CW-1:0] r_cnt;
         logic          r_err;
         logic          w_partial;

         assign w_partial = (r_state == ARMED) & ~w_s_complete & ~w_s_spacer;

         // err sets only on the cycle the count reaches TIMEOUT, so a clear
         // while still stuck and saturated does take effect.
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               r_cnt <= '0;
               r_err <= 1'b0;
            end else begin
               if (!w_partial)
                  r_cnt <= '0;
               else if (r_cnt != CW'(TIMEOUT))
                  r_cnt <= r_cnt + 1'b1;

               if (w_partial && (r_cnt == CW'(TIMEOUT - 1)))
                  r_err <= 1'b1;
               else if (err_clr)
                  r_err <= 1'b0;
            end
         end

         assign err = r_err;
      end else begin : g_no_timeout
         logic w_unused_clr;
         assign w_unused_clr = err_clr;
         assign err          = 1'b0;
      end
   endgenerate

endmodule
`default_nettype wire

// File: rtl/done_track_n.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | done_track_n : N-channel dual-rail completion tracker, sync output |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module done_track_n
   import done_track_n_pkg::*;
#(
   parameter int N           = 2,
   parameter int BITS        = DEF_BITS,
   parameter int SYNC_STAGES = 2,
   parameter int TIMEOUT     = 16
) (
   input  wire logic        clk,
   input  wire logic        rst_n,
   done_track_n_if.slave    bus
);
   generate
      for (genvar g = 0; g < N; g++) begin : g_chan
         done_chan #(
            .BITS        (BITS),
            .SYNC_STAGES (SYNC_STAGES),
            .TIMEOUT     (TIMEOUT)
         ) u_chan (
            .clk        (clk),
            .rst_n      (rst_n),
            .val0       (bus.val0[g]),
            .val1       (bus.val1[g]),
            .ack        (bus.ack[g]),
            .err_clr    (bus.err_clr[g]),
            .done       (bus.done[g]),
            .done_pulse (bus.done_pulse[g]),
            .err        (bus.err[g])
         );
      end
   endgenerate

   assign bus.all_done = &bus.done;

endmodule
`default_nettype wire

// File: tb/tb_done_track_n.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_done_track_n : directed self-checking bench for done_track_n    |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module tb_done_track_n;
   import done_track_n_pkg::*;

   logic clk = 1'b0;
   logic rst_n;
   logic rst_b;
   int   n_tests = 0;
   int   n_fail  = 0;

   always #5 clk = ~clk;

   done_track_n_if #(.N(2), .BITS(4)) bus_a ();
   done_track_n_if #(.N(1), .BITS(1)) bus_b ();

   done_track_n #(.N(2), .BITS(4), .SYNC_STAGES(2), .TIMEOUT(8)) u_dut_a (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus_a.slave)
   );

   done_track_n #(.N(1), .BITS(1), .SYNC_STAGES(2), .TIMEOUT(0)) u_dut_b (
      .clk   (clk),
      .rst_n (rst_b),
      .bus   (bus_b.slave)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic rails_a(input int ch, input logic [3:0] v0, input logic [3:0] v1);
      bus_a.val0[ch] = v0;
      bus_a.val1[ch] = v1;
   endtask

   initial begin
      int npulse;
      rst_n = 1'b0;
      rst_b = 1'b0;
      rails_a(0, 4'hA, 4'h5);
      rails_a(1, 4'hA, 4'h5);
      bus_a.ack = '0;  bus_a.err_clr = '0;
      bus_b.val0 = 1'b1; bus_b.val1 = 1'b0;
      bus_b.ack = '0;  bus_b.err_clr = '0;
      ticks(3);

      // Release reset with rails already complete: no done without a spacer.
      rst_n = 1'b1;
      ticks(5);
      check("rst_done", 32'(bus_a.done), 32'h0);
      check("rst_err", 32'(bus_a.err), 32'h0);
      check("rst_all", 32'(bus_a.all_done), 32'h0);

      // Spacer then data: done on the 3rd edge, one-cycle pulse.
      rails_a(0, 4'h0, 4'h0);
      rails_a(1, 4'h0, 4'h0);
      ticks(4);
      rails_a(0, 4'h3, 4'hC);
      ticks(2);
      check("lat_e2", 32'(bus_a.done[0]), 32'h0);
      tick();
      check("lat_e3", 32'(bus_a.done[0]), 32'h1);
      check("pulse_on", 32'(bus_a.done_pulse[0]), 32'h1);
      tick();
      check("pulse_off", 32'(bus_a.done_pulse[0]), 32'h0);

      // Handshake: done holds until ack, ack held high causes nothing more.
      ticks(10);
      check("hold_done", 32'(bus_a.done[0]), 32'h1);
      bus_a.ack[0] = 1'b1;
      tick();
      check("ack_fall", 32'(bus_a.done[0]), 32'h0);
      ticks(3);
      bus_a.ack[0] = 1'b0;
      rails_a(0, 4'h9, 4'h6);
      ticks(6);
      check("no_spacer", 32'(bus_a.done[0]), 32'h0);

      // Independence and all_done.
      rails_a(0, 4'h0, 4'h0);
      ticks(4);
      rails_a(0, 4'h5, 4'hA);
      ticks(5);
      check("ch0_only", 32'(bus_a.done), 32'h1);
      rails_a(1, 4'h1, 4'hE);
      ticks(2);
      check("all_early", 32'(bus_a.all_done), 32'h0);
      tick();
      check("all_set", 32'(bus_a.all_done), 32'h1);
      check("both_done", 32'(bus_a.done), 32'h3);
      bus_a.ack[0] = 1'b1;
      tick();
      bus_a.ack[0] = 1'b0;
      check("all_clr", 32'(bus_a.all_done), 32'h0);
      check("ch1_kept", 32'(bus_a.done[1]), 32'h1);
      bus_a.ack[1] = 1'b1;
      tick();
      bus_a.ack[1] = 1'b0;
      check("ch1_ack", 32'(bus_a.done), 32'h0);

      // Timeout: 3 of 4 bits complete in ARMED; count hits 8 on edge 10.
      rails_a(0, 4'h0, 4'h0);
      rails_a(1, 4'h0, 4'h0);
      ticks(4);
      rails_a(0, 4'h7, 4'h0);
      ticks(9);
      check("to_early", 32'(bus_a.err[0]), 32'h0);
      tick();
      check("to_set", 32'(bus_a.err[0]), 32'h1);
      check("to_nodone", 32'(bus_a.done[0]), 32'h0);
      check("to_ch1", 32'(bus_a.err[1]), 32'h0);
      rails_a(0, 4'hF, 4'h0);
      ticks(3);
      check("to_done", 32'(bus_a.done[0]), 32'h1);
      check("to_sticky", 32'(bus_a.err[0]), 32'h1);
      bus_a.ack[0] = 1'b1;
      tick();
      bus_a.ack[0] = 1'b0;
      check("to_sticky2", 32'(bus_a.err[0]), 32'h1);
      bus_a.err_clr[0] = 1'b1;
      tick();
      bus_a.err_clr[0] = 1'b0;
      check("to_clr", 32'(bus_a.err[0]), 32'h0);

      // Set and clear on the same edge: set wins.
      rails_a(0, 4'h0, 4'h0);
      ticks(4);
      rails_a(0, 4'h7, 4'h0);
      bus_a.err_clr[0] = 1'b1;
      ticks(9);
      check("sw_pre", 32'(bus_a.err[0]), 32'h0);
      tick();
      bus_a.err_clr[0] = 1'b0;
      check("set_wins", 32'(bus_a.err[0]), 32'h1);
      rails_a(0, 4'hF, 4'h0);
      ticks(3);
      check("sw_done", 32'(bus_a.done[0]), 32'h1);

      // Asynchronous reset in DONE, away from any clock edge.
      #2;
      rst_n = 1'b0;
      #1;
      check("arst_done", 32'(bus_a.done), 32'h0);
      check("arst_err", 32'(bus_a.err), 32'h0);
      check("arst_all", 32'(bus_a.all_done), 32'h0);
      ticks(2);
      rst_n = 1'b1;

      // Glitches: one between edges is invisible, one across an edge gives one done.
      rails_a(0, 4'h0, 4'h0);
      ticks(4);
      #2;
      rails_a(0, 4'hF, 4'h0);
      #3;
      rails_a(0, 4'h0, 4'h0);
      ticks(6);
      check("glitch_in", 32'(bus_a.done[0]), 32'h0);
      #6;
      rails_a(0, 4'hF, 4'h0);
      #4;
      rails_a(0, 4'h0, 4'h0);
      npulse = 0;
      for (int i = 0; i < 8; i++) begin
         tick();
         if (bus_a.done_pulse[0]) npulse++;
      end
      check("glitch_pulses", 32'(npulse), 32'd1);
      check("glitch_done", 32'(bus_a.done[0]), 32'h1);

      // Corner instance: N=1, BITS=1, TIMEOUT=0, two full cycles.
      rst_b = 1'b1;
      ticks(5);
      check("b_rst_done", 32'(bus_b.done), 32'h0);
      for (int r = 0; r < 2; r++) begin
         bus_b.val0 = 1'b0; bus_b.val1 = 1'b0;
         ticks(4);
         bus_b.val0 = (r == 0) ? 1'b1 : 1'b0;
         bus_b.val1 = (r == 0) ? 1'b0 : 1'b1;
         ticks(2);
         check("b_lat_e2", 32'(bus_b.done), 32'h0);
         tick();
         check("b_lat_e3", 32'(bus_b.done), 32'h1);
         check("b_pulse", 32'(bus_b.done_pulse), 32'h1);
         check("b_all", 32'(bus_b.all_done), 32'h1);
         bus_b.ack = 1'b1;
         tick();
         bus_b.ack = 1'b0;
         check("b_ack", 32'(bus_b.done), 32'h0);
         check("b_err", 32'(bus_b.err), 32'h0);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
